// File: rtl/tick_bcd_counter_pkg.sv
// tick_bcd_counter_pkg
//   Shared definitions for the tick-driven BCD counter:
//   - bcd_t        : two-digit BCD count (tens, ones)
//   - SEG_*        : active-high 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   - mod_is_legal : modulus legality check (2..100), used at elaboration
//   - bcd_limit    : splits MOD-1 into its tens/ones digits
package tick_bcd_counter_pkg;

  localparam int unsigned MOD_MIN = 2;
  localparam int unsigned MOD_MAX = 100;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic bit mod_is_legal(input int unsigned m);
    return (m >= MOD_MIN) && (m <= MOD_MAX);
  endfunction

  // Highest reachable count (MOD-1) expressed directly as BCD digits.
  function automatic bcd_t bcd_limit(input int unsigned m);
    bcd_t r;
    r.tens = 4'((m - 1) / 10);
    r.ones = 4'((m - 1) % 10);
    return r;
  endfunction

endpackage

// File: rtl/tick_bcd_counter_if.sv
// tick_bcd_counter_if
//   Control and display bundle of the tick-driven BCD counter.
//   Controls : tick_in (async slow square wave), en, up, clr
//   Display  : ones/tens (BCD), seg_ones/seg_tens (7-segment)
//   Strobes  : step (edge seen), wrap (modulus boundary crossed)
//   master : drives the controls, observes the display/strobes
//   slave  : the counter itself
interface tick_bcd_counter_if;

  logic       tick_in;
  logic       en;
  logic       up;
  logic       clr;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [6:0] seg_ones;
  logic [6:0] seg_tens;
  logic       step;
  logic       wrap;

  modport master (
    output tick_in, en, up, clr,
    input  ones, tens, seg_ones, seg_tens, step, wrap
  );

  modport slave (
    input  tick_in, en, up, clr,
    output ones, tens, seg_ones, seg_tens, step, wrap
  );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode
//   Purely combinational BCD digit to 7-segment pattern decoder.
//   digit : 4-bit BCD digit in (0..9)
//   seg   : active-high pattern {g,f,e,d,c,b,a}; blank for codes 10..15
module seg7_decode
  import tick_bcd_counter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter
//   Synchronises the divided slow square wave, detects its rising edges and
//   steps a two-digit BCD modulo-MOD counter up or down on each one.
//   modulus parameter : 2..100; count runs 0..MOD-1
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of tick_bcd_counter_if
//           (tick_in/en/up/clr in; ones/tens/seg_ones/seg_tens/step/wrap out)
module tick_bcd_counter
  import tick_bcd_counter_pkg::*;
#(
  parameter int unsigned MOD = 60
) (
  input logic                clk,
  input logic                rst_n,
  tick_bcd_counter_if.slave  bus
);

  if (!mod_is_legal(MOD)) begin : g_mod_check
    $error("tick_bcd_counter: MOD=%0d outside legal range 2..100", MOD);
  end

  localparam bcd_t TOP = bcd_limit(MOD);

  // ---------------------------------------------------------------------
  // Synchroniser and rising-edge detect. s3 resets low, so a tick_in that
  // is already high when reset releases is reported as one rising edge.
  // ---------------------------------------------------------------------
  logic s1;
  logic s2;
  logic s3;
  logic edge_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_seen = s2 & ~s3;

  // ---------------------------------------------------------------------
  // BCD counter. Priority: clr, then enabled edge, then hold.
  // ---------------------------------------------------------------------
  bcd_t cnt;
  bcd_t cnt_nxt;
  logic wrap_nxt;
  logic step_q;
  logic wrap_q;

  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (bus.clr) begin
      cnt_nxt = '0;
    end else if (edge_seen && bus.en) begin
      if (bus.up) begin
        if (cnt == TOP) begin
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
        end else if (cnt.ones == DIGIT_MAX) begin
          cnt_nxt.ones = '0;
          cnt_nxt.tens = cnt.tens + 4'd1;
        end else begin
          cnt_nxt.ones = cnt.ones + 4'd1;
        end
      end else begin
        if (cnt == '0) begin
          cnt_nxt  = TOP;
          wrap_nxt = 1'b1;
        end else if (cnt.ones == '0) begin
          cnt_nxt.ones = DIGIT_MAX;
          cnt_nxt.tens = cnt.tens - 4'd1;
        end else begin
          cnt_nxt.ones = cnt.ones - 4'd1;
        end
      end
    end
  end

  // step follows every detected edge, even when clr or en=0 suppress counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      step_q <= edge_seen;
      wrap_q <= wrap_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Display outputs
  // ---------------------------------------------------------------------
  logic [6:0] seg_ones;
  logic [6:0] seg_tens;

  seg7_decode u_seg_ones (
    .digit (cnt.ones),
    .seg   (seg_ones)
  );

  seg7_decode u_seg_tens (
    .digit (cnt.tens),
    .seg   (seg_tens)
  );

  assign bus.ones     = cnt.ones;
  assign bus.tens     = cnt.tens;
  assign bus.seg_ones = seg_ones;
  assign bus.seg_tens = seg_tens;
  assign bus.step     = step_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// tb_tick_bcd_counter
//   Drives three counters (MOD = 60, 2, 100) with one shared stimulus and
//   compares every output each cycle against an arithmetic reference model.
module tb_tick_bcd_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick;
  logic en;
  logic up;
  logic clr;

  always #5 clk = ~clk;

  tick_bcd_counter_if b60 ();
  tick_bcd_counter_if b2 ();
  tick_bcd_counter_if b100 ();

  assign b60.tick_in  = tick;
  assign b60.en       = en;
  assign b60.up       = up;
  assign b60.clr      = clr;
  assign b2.tick_in   = tick;
  assign b2.en        = en;
  assign b2.up        = up;
  assign b2.clr       = clr;
  assign b100.tick_in = tick;
  assign b100.en      = en;
  assign b100.up      = up;
  assign b100.clr     = clr;

  tick_bcd_counter #(.MOD(60)) dut60 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b60)
  );

  tick_bcd_counter #(.MOD(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  tick_bcd_counter #(.MOD(100)) dut100 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b100)
  );

  // Reference model: integer count per modulus, tick_in sampled per edge.
  int   mods [3] = '{60, 2, 100};
  int   cnt  [3];
  bit   exp_wrap [3];
  bit   exp_step;
  bit   smp [3];
  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111};

  int tests = 0;
  int fails = 0;
  int steps60 = 0;
  int wraps60 = 0;
  int wraps2 = 0;
  int wraps100 = 0;
  int s0;
  int w0;

  task automatic chk(input string name, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i]      = 0;
      exp_wrap[i] = 1'b0;
      smp[i]      = 1'b0;
    end
    exp_step = 1'b0;
  endtask

  // A rise is recognised when the sample two edges back is 1 and the one
  // three edges back is 0; the new count is visible after that edge.
  task automatic model_edge();
    bit rise;
    rise = smp[1] && !smp[2];
    exp_step = rise;
    for (int i = 0; i < 3; i++) begin
      exp_wrap[i] = 1'b0;
      if (clr) begin
        cnt[i] = 0;
      end else if (rise && en) begin
        if (up) begin
          cnt[i] = cnt[i] + 1;
          if (cnt[i] == mods[i]) begin
            cnt[i] = 0;
            exp_wrap[i] = 1'b1;
          end
        end else if (cnt[i] == 0) begin
          cnt[i] = mods[i] - 1;
          exp_wrap[i] = 1'b1;
        end else begin
          cnt[i] = cnt[i] - 1;
        end
      end
    end
    smp[2] = smp[1];
    smp[1] = smp[0];
    smp[0] = (tick === 1'b1);
  endtask

  task automatic check_one(input string tag, input int i,
                           input logic [3:0] o, input logic [3:0] t,
                           input logic [6:0] so, input logic [6:0] st,
                           input logic s, input logic w);
    chk({tag, ".ones"}, {3'b0, o}, 7'(cnt[i] % 10));
    chk({tag, ".tens"}, {3'b0, t}, 7'(cnt[i] / 10));
    chk({tag, ".seg_ones"}, so, seg_tab[cnt[i] % 10]);
    chk({tag, ".seg_tens"}, st, seg_tab[cnt[i] / 10]);
    chk({tag, ".step"}, {6'b0, s}, {6'b0, exp_step});
    chk({tag, ".wrap"}, {6'b0, w}, {6'b0, exp_wrap[i]});
  endtask

  task automatic check_all();
    check_one("m60", 0, b60.ones, b60.tens, b60.seg_ones, b60.seg_tens, b60.step, b60.wrap);
    check_one("m2", 1, b2.ones, b2.tens, b2.seg_ones, b2.seg_tens, b2.step, b2.wrap);
    check_one("m100", 2, b100.ones, b100.tens, b100.seg_ones, b100.seg_tens,
              b100.step, b100.wrap);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    if (b60.step === 1'b1) steps60++;
    if (b60.wrap === 1'b1) wraps60++;
    if (b2.wrap === 1'b1) wraps2++;
    if (b100.wrap === 1'b1) wraps100++;
    check_all();
  endtask

  task automatic pulse(input int hi, input int lo);
    tick = 1'b1;
    repeat (hi) cyc();
    tick = 1'b0;
    repeat (lo) cyc();
  endtask

  initial begin
    tick = 1'b0;
    en   = 1'b1;
    up   = 1'b1;
    clr  = 1'b0;
    model_reset();

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("rst_ones", {3'b0, b60.ones}, 7'd0);
    chk("rst_seg_tens", b60.seg_tens, 7'b0111111);
    chk("rst_step", {6'b0, b60.step}, 7'd0);

    // Count up to 59, then wrap on the 60th edge
    repeat (59) pulse(2, 2);
    chk("up59_tens", {3'b0, b60.tens}, 7'd5);
    chk("up59_ones", {3'b0, b60.ones}, 7'd9);
    chk("up59_seg_tens", b60.seg_tens, 7'b1101101);
    chk("up59_seg_ones", b60.seg_ones, 7'b1101111);
    tick = 1'b1;
    cyc();
    chk("latency_no_step_e0", {6'b0, b60.step}, 7'd0);
    cyc();
    chk("latency_no_step_e1", {6'b0, b60.step}, 7'd0);
    tick = 1'b0;
    cyc();
    chk("wrap60_step", {6'b0, b60.step}, 7'd1);
    chk("wrap60_wrap", {6'b0, b60.wrap}, 7'd1);
    chk("wrap60_ones", {3'b0, b60.ones}, 7'd0);
    cyc();
    chk("wrap60_one_cycle", {6'b0, b60.wrap}, 7'd0);

    // Count down from 00
    up = 1'b0;
    w0 = wraps60;
    pulse(2, 2);
    chk("down_wrap_tens", {3'b0, b60.tens}, 7'd5);
    chk("down_wrap_ones", {3'b0, b60.ones}, 7'd9);
    chk("down_wrap_count", 7'(wraps60 - w0), 7'd1);
    w0 = wraps60;
    pulse(2, 2);
    chk("down58_ones", {3'b0, b60.ones}, 7'd8);
    chk("down58_nowrap", 7'(wraps60 - w0), 7'd0);
    repeat (48) pulse(2, 3);
    chk("down10_tens", {3'b0, b60.tens}, 7'd1);
    pulse(3, 2);
    chk("down09_tens", {3'b0, b60.tens}, 7'd0);
    chk("down09_ones", {3'b0, b60.ones}, 7'd9);

    // Edges with en=0: step pulses, count held
    en = 1'b0;
    s0 = steps60;
    w0 = wraps60;
    repeat (5) pulse(2, 2);
    chk("en0_steps", 7'(steps60 - s0), 7'd5);
    chk("en0_wraps", 7'(wraps60 - w0), 7'd0);
    chk("en0_ones", {3'b0, b60.ones}, 7'd9);
    en = 1'b1;

    // clr coincident with an edge at 37
    up  = 1'b1;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (37) pulse(2, 2);
    chk("at37_tens", {3'b0, b60.tens}, 7'd3);
    chk("at37_ones", {3'b0, b60.ones}, 7'd7);
    s0 = steps60;
    w0 = wraps60;
    clr = 1'b1;
    pulse(2, 2);
    clr = 1'b0;
    chk("clr_edge_tens", {3'b0, b60.tens}, 7'd0);
    chk("clr_edge_ones", {3'b0, b60.ones}, 7'd0);
    chk("clr_edge_step", 7'(steps60 - s0), 7'd1);
    chk("clr_edge_wrap", 7'(wraps60 - w0), 7'd0);

    // Two-state counter: 0,1,0 with wrap on the return to 0
    pulse(2, 2);
    chk("m2_one", {3'b0, b2.ones}, 7'd1);
    w0 = wraps2;
    pulse(2, 2);
    chk("m2_zero", {3'b0, b2.ones}, 7'd0);
    chk("m2_wrap", 7'(wraps2 - w0), 7'd1);

    // Hundred-state counter: 00 down to 99, then 99 up to 00 with wrap
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    up = 1'b0;
    pulse(2, 2);
    chk("m100_99_tens", {3'b0, b100.tens}, 7'd9);
    chk("m100_99_ones", {3'b0, b100.ones}, 7'd9);
    up = 1'b1;
    w0 = wraps100;
    pulse(2, 2);
    chk("m100_00_tens", {3'b0, b100.tens}, 7'd0);
    chk("m100_wrap", 7'(wraps100 - w0), 7'd1);

    // Asynchronous reset mid-cycle at 42
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (42) pulse(2, 2);
    chk("at42_tens", {3'b0, b60.tens}, 7'd4);
    chk("at42_ones", {3'b0, b60.ones}, 7'd2);
    cyc();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_tens", {3'b0, b60.tens}, 7'd0);
    chk("async_rst_seg_ones", b60.seg_ones, 7'b0111111);
    tick = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("high_at_release_ones", {3'b0, b60.ones}, 7'd1);
    tick = 1'b0;
    repeat (3) cyc();

    // Sub-cycle glitch between clock edges
    s0 = steps60;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    #2 tick = 1'b1;
    #4 tick = 1'b0;
    repeat (5) cyc();
    chk("glitch_no_step", 7'(steps60 - s0), 7'd0);

    // Randomised edges, enables, directions and clears
    repeat (300) begin
      en  = ($urandom_range(0, 3) != 0);
      up  = $urandom_range(0, 1) != 0;
      clr = ($urandom_range(0, 15) == 0);
      pulse($urandom_range(2, 5), $urandom_range(2, 5));
    end
    clr = 1'b0;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
